// File: rtl/whack_pkg.sv
// Shared types and helpers for the whack event encoder.
package whack_pkg;

  localparam int NUM_HOLES_DEF = 18;
  localparam int MAX_HOLES = 32;

  function automatic int hole_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int HOLE_IDX_W = hole_idx_w(NUM_HOLES_DEF);

  typedef struct packed {
    logic [HOLE_IDX_W-1:0] hole;
  } whack_evt_t;

  function automatic logic [HOLE_IDX_W-1:0] lowest_set(
    input logic [MAX_HOLES-1:0] v
  );
    lowest_set = '0;
    for (int i = MAX_HOLES - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = HOLE_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/whack_fifo.sv
// Synchronous event FIFO with flush; head is combinational from storage.
module whack_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop, do_push;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + AW'(1);
    end
    if (do_pop) rptr_d = rptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rptr_q];

endmodule

// File: rtl/whack_encoder.sv
// Switch toggle -> whack event stream producer.
// Optional per-hole re-trigger lockout under WHACK_LOCKOUT_EN.
module whack_encoder
  import whack_pkg::*;
#(
  parameter int NUM_HOLES   = 18,
  parameter int FIFO_DEPTH  = 4,
  parameter int CLKS_PER_MS = 50000,
  parameter int LOCKOUT_MS  = 150
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_HOLES-1:0]         switches,
  input  logic                         enable,
  output logic                         whack_valid,
  output logic [$clog2(NUM_HOLES)-1:0] whack_hole,
  input  logic                         whack_ready,
  output logic                         overflow
);

  localparam int N  = NUM_HOLES;
  localparam int IW = $clog2(NUM_HOLES);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [N-1:0]  s1_q, s1_d, s2_q, s2_d;
  logic [N-1:0]  prev_q, prev_d, pend_q, pend_d;
  logic [1:0]    prime_q, prime_d;
  logic          en_q, en_d, ovf_q, ovf_d;
  logic          primed, push, pop, full;
  logic [N-1:0]  edges, acc, pushed, kept, locked;
  logic [CW-1:0] count;
  whack_evt_t    evt;

`ifdef WHACK_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_MS + 1);
  localparam int TW = hole_idx_w(CLKS_PER_MS);

  logic [TW-1:0] tick_q, tick_d;
  logic [LW-1:0] lock_q [N];
  logic [LW-1:0] lock_d [N];
  logic          tick;

  always_comb begin
    tick   = (tick_q == TW'(CLKS_PER_MS - 1));
    tick_d = tick ? '0 : tick_q + TW'(1);
    for (int i = 0; i < N; i++) begin
      locked[i] = (lock_q[i] != '0);
      lock_d[i] = lock_q[i];
      if (tick && locked[i]) lock_d[i] = lock_q[i] - LW'(1);
      if (acc[i]) lock_d[i] = LW'(LOCKOUT_MS);
      if (!enable) lock_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      for (int i = 0; i < N; i++) lock_q[i] <= '0;
    end else begin
      tick_q <= tick_d;
      lock_q <= lock_d;
    end
  end
`else
  assign locked = '0;
`endif

  always_comb begin
    s1_d    = switches;
    s2_d    = s1_q;
    prev_d  = s2_q;
    en_d    = enable;
    primed  = (prime_q == 2'd3);
    prime_d = primed ? prime_q : prime_q + 2'd1;
    edges   = primed ? (s2_q ^ prev_q) : '0;
    acc     = enable ? (edges & ~locked) : '0;
    evt     = '{hole: lowest_set(MAX_HOLES'(pend_q))};
    pop     = whack_valid && whack_ready;
    push    = enable && (|pend_q) && (!full || pop);
    pushed  = push ? (N'(1) << evt.hole) : '0;
    kept    = pend_q & ~pushed;
    pend_d  = enable ? (kept | acc) : '0;
    ovf_d   = ovf_q;
    if (enable && !en_q) ovf_d = 1'b0;
    // edge on a still-queued pending hole has nowhere to go
    if (|(acc & kept)) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      prime_q <= '0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      prime_q <= prime_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
    end
  end

  whack_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (IW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (!enable),
    .push  (push),
    .pop   (pop),
    .din   (IW'(evt.hole)),
    .dout  (whack_hole),
    .full  (full),
    .count (count)
  );

  assign whack_valid = (count != '0);
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_whack_encoder.sv
// Randomized + directed bench for whack_encoder with a queue-based reference model.
module tb_whack_encoder;

  localparam int N  = 18;
  localparam int D  = 4;
  localparam int IW = 5;
`ifdef WHACK_LOCKOUT_EN
  localparam int CPM = 10;
  localparam int LMS = 2;
  localparam int GAP = 40;
`else
  localparam int CPM = 50000;
  localparam int LMS = 150;
  localparam int GAP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          whack_ready = 1'b0;
  logic [N-1:0]  switches = '0;
  logic          whack_valid;
  logic [IW-1:0] whack_hole;
  logic          overflow;

  whack_encoder #(
    .NUM_HOLES   (N),
    .FIFO_DEPTH  (D),
    .CLKS_PER_MS (CPM),
    .LOCKOUT_MS  (LMS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .switches    (switches),
    .enable      (enable),
    .whack_valid (whack_valid),
    .whack_hole  (whack_hole),
    .whack_ready (whack_ready),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;
  int got[$];
  int last_tog[N];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: three-stage delay to the edge, then a pending set
  // draining lowest-first into a bounded queue.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_prev = '0;
  int m_prime = 0;
  bit m_pend[N];
  int m_q[$];
  bit m_ovf = 1'b0;
  bit m_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [N-1:0] e;
    int pick;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0;
      m_prime = 0; m_ovf = 1'b0; m_en = 1'b0;
      m_q.delete();
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    end else begin
      e = (m_prime >= 3) ? (m_s2 ^ m_prev) : '0;
      if (m_prime < 3) m_prime++;
      if (!enable) begin
        m_q.delete();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      end else begin
        if (!m_en) m_ovf = 1'b0;
        if (m_q.size() > 0 && whack_ready) void'(m_q.pop_front());
        pick = -1;
        for (int i = 0; i < N; i++) if (m_pend[i] && pick < 0) pick = i;
        if (pick >= 0 && m_q.size() < D) begin
          m_q.push_back(pick);
          m_pend[pick] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
          if (e[i]) begin
            if (m_pend[i]) m_ovf = 1'b1;
            else m_pend[i] = 1'b1;
          end
        end
      end
      m_en = enable;
      m_prev = m_s2;
      m_s2 = m_s1;
      m_s1 = switches;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", 32'(whack_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("hole", 32'(whack_hole), 32'(m_q[0]));
      chk("ovf", 32'(overflow), 32'(m_ovf));
    end
    if (whack_valid && whack_ready) got.push_back(int'(whack_hole));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tog(input int h);
    switches[h] = ~switches[h];
  endtask

  function automatic int got_at(input int i);
    return (i < got.size()) ? got[i] : -1;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) last_tog[i] = -1000;
    // 1: reset with switches held, no events on release
    switches = 18'h00005;
    tick(1);
    chk_on = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    chk("t1_valid", 32'(whack_valid), 32'd0);
    chk("t1_ovf", 32'(overflow), 32'd0);

    // 2: single toggle latency and single-cycle pulse
    enable = 1'b1;
    whack_ready = 1'b1;
    tick(GAP + 5);
    tog(7);
    tick(3);
    chk("t2_n2", 32'(whack_valid), 32'd0);
    tick(1);
    chk("t2_n3", 32'(whack_valid), 32'd1);
    chk("t2_hole", 32'(whack_hole), 32'd7);
    tick(1);
    chk("t2_once", 32'(whack_valid), 32'd0);

    // 3: simultaneous toggles deliver lowest-first
    whack_ready = 1'b0;
    tick(GAP);
    tog(2); tog(9); tog(0);
    tick(6);
    chk("t3_head", 32'(whack_hole), 32'd0);
    got.delete();
    whack_ready = 1'b1;
    tick(6);
    chk("t3_n", 32'(got.size()), 32'd3);
    chk("t3_0", 32'(got_at(0)), 32'd0);
    chk("t3_1", 32'(got_at(1)), 32'd2);
    chk("t3_2", 32'(got_at(2)), 32'd9);

    // 4: fill FIFO, leave two pending, coalesce a retoggle
    whack_ready = 1'b0;
    tick(GAP + 2);
    got.delete();
    for (int i = 0; i < 6; i++) begin
      tog(i);
      tick(1);
    end
    tick(5);
    chk("t4_full", 32'(whack_valid), 32'd1);
    chk("t4_ovf0", 32'(overflow), 32'd0);
    tick(40);
    tog(4);
    tick(4);
    chk("t4_ovf1", 32'(overflow), 32'd1);
    whack_ready = 1'b1;
    tick(12);
    chk("t4_n", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk("t4_seq", 32'(got_at(i)), 32'(i));

    // 5: disable flushes; toggles while disabled never fire
    whack_ready = 1'b0;
    tick(GAP);
    tog(10); tog(11); tog(12);
    tick(6);
    chk("t5_q", 32'(whack_valid), 32'd1);
    enable = 1'b0;
    tick(1);
    chk("t5_flush", 32'(whack_valid), 32'd0);
    tog(3);
    tick(5);
    enable = 1'b1;
    whack_ready = 1'b1;
    got.delete();
    tick(10);
    chk("t5_none", 32'(got.size()), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);

    // async reset mid-stream drops queued events
    whack_ready = 1'b0;
    tog(13); tog(14);
    tick(6);
    chk("rst_pre", 32'(whack_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(whack_valid), 32'd0);
    chk("rst_hole", 32'(whack_hole), 32'd0);
    tick(2);
    rst_n = 1'b1;
    whack_ready = 1'b1;
    tick(10);
    chk("rst_post", 32'(whack_valid), 32'd0);

    // random traffic against the model
    tick(GAP);
    for (int c = 0; c < 500; c++) begin
      whack_ready = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 2) == 0) begin
        int h;
        h = $urandom_range(0, N - 1);
        if (c - last_tog[h] >= GAP) begin
          tog(h);
          last_tog[h] = c;
        end
      end
      tick(1);
    end
    enable = 1'b1;
    whack_ready = 1'b1;
    tick(GAP + 20);
    chk("rnd_drain", 32'(whack_valid), 32'd0);

`ifdef WHACK_LOCKOUT_EN
    // 6: retoggle inside lockout window is ignored
    chk_on = 1'b0;
    tick(40);
    got.delete();
    tog(1);
    tick(5);
    tog(1);
    tick(30);
    tog(1);
    tick(20);
    chk("t6_n", 32'(got.size()), 32'd2);
    chk("t6_a", 32'(got_at(0)), 32'd1);
    chk("t6_b", 32'(got_at(1)), 32'd1);
    chk("t6_ovf", 32'(overflow), 32'd0);
    tick(5);
    chk_on = 1'b1;
    tick(5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
